// File: rtl/lsu_load_unit.sv
// Load unit: takes one RV32 load request, issues one AXI4-Lite read on the word address, extends the addressed lane.
// Latency: zero-wait slave gives resp_valid 3 cycles after acceptance; illegal/misaligned requests respond after 1 cycle.
// Backpressure: single outstanding load; req_ready only in IDLE, result held in RESP until resp_ready.
module lsu_load_unit #(
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [2:0]            req_func3,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [31:0]           resp_data,
    output logic                  resp_err,
    output logic [ADDR_WIDTH-1:0] araddr,
    output logic                  arvalid,
    input  logic                  arready,
    input  logic [31:0]           rdata,
    input  logic [1:0]            rresp,
    input  logic                  rvalid,
    output logic                  rready
);

    // Counter only needs to reach TIMEOUT_CYCLES-1; expiry is detected on that value.
    localparam int CW      = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int TO_LAST = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_AR,
        S_R,
        S_RESP
    } state_t;

    state_t                r_state;
    logic [1:0]            r_off;
    logic [2:0]            r_func3;
    logic [ADDR_WIDTH-1:0] r_araddr;
    logic [31:0]           r_resp_data;
    logic                  r_resp_err;
    logic [CW-1:0]         r_cnt;

    logic                  w_req_legal;
    logic                  w_expired;
    logic [7:0]            w_byte;
    logic [15:0]           w_half;
    logic [31:0]           w_ext;

    // Request legality: known func3 and natural alignment for the access size.
    always_comb begin
        w_req_legal = 1'b0;
        case (req_func3)
            3'b000, 3'b100: w_req_legal = 1'b1;
            3'b001, 3'b101: w_req_legal = ~req_addr[0];
            3'b010:         w_req_legal = (req_addr[1:0] == 2'b00);
            default:        w_req_legal = 1'b0;
        endcase
    end

    // Lane select and sign/zero extension of the returned beat.
    always_comb begin
        w_byte = rdata[{r_off, 3'b000} +: 8];
        w_half = rdata[{r_off[1], 4'b0000} +: 16];
        case (r_func3)
            3'b000:  w_ext = {{24{w_byte[7]}}, w_byte};
            3'b100:  w_ext = {24'h000000, w_byte};
            3'b001:  w_ext = {{16{w_half[15]}}, w_half};
            3'b101:  w_ext = {16'h0000, w_half};
            default: w_ext = rdata;
        endcase
    end

    assign w_expired = (TIMEOUT_CYCLES > 0) && (r_cnt == CW'(TO_LAST));

    // Main control FSM; all datapath outputs are registered here.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_off       <= 2'b00;
            r_func3     <= 3'b000;
            r_araddr    <= '0;
            r_resp_data <= 32'h0;
            r_resp_err  <= 1'b0;
            r_cnt       <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_off   <= req_addr[1:0];
                        r_func3 <= req_func3;
                        r_cnt   <= '0;
                        if (w_req_legal) begin
                            r_araddr <= {req_addr[ADDR_WIDTH-1:2], 2'b00};
                            r_state  <= S_AR;
                        end else begin
                            r_resp_data <= 32'h0;
                            r_resp_err  <= 1'b1;
                            r_state     <= S_RESP;
                        end
                    end
                end
                S_AR: begin
                    // A handshake on the last allowed cycle still proceeds to R.
                    if (arready) begin
                        r_cnt   <= '0;
                        r_state <= S_R;
                    end else if (w_expired) begin
                        r_resp_data <= 32'h0;
                        r_resp_err  <= 1'b1;
                        r_state     <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_R: begin
                    // Data arriving on the expiry cycle wins over the timeout.
                    if (rvalid) begin
                        if (rresp != 2'b00) begin
                            r_resp_data <= 32'h0;
                            r_resp_err  <= 1'b1;
                        end else begin
                            r_resp_data <= w_ext;
                            r_resp_err  <= 1'b0;
                        end
                        r_state <= S_RESP;
                    end else if (w_expired) begin
                        r_resp_data <= 32'h0;
                        r_resp_err  <= 1'b1;
                        r_state     <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_RESP: begin
                    if (resp_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign req_ready  = (r_state == S_IDLE);
    assign arvalid    = (r_state == S_AR);
    assign rready     = (r_state == S_R);
    assign resp_valid = (r_state == S_RESP);
    assign araddr     = r_araddr;
    assign resp_data  = r_resp_data;
    assign resp_err   = r_resp_err;

endmodule

// File: tb/tb_lsu_load_unit.sv
// Bench for lsu_load_unit: transaction model predicts the per-cycle phase timeline and response values.
// Stimulus drives inputs on the falling edge; outputs are compared 1 time unit after the rising edge.
// Slave delays, func3/addresses, bus errors, stray requests and mid-transaction resets are randomized.
module tb_lsu_load_unit;

    localparam int AW = 32;
    localparam int TO = 8;

    localparam logic [1:0] P_IDLE = 2'd0;
    localparam logic [1:0] P_AR   = 2'd1;
    localparam logic [1:0] P_R    = 2'd2;
    localparam logic [1:0] P_RESP = 2'd3;

    typedef struct packed {
        logic [1:0]  ph;
        logic [31:0] ad;
        logic [31:0] d;
        logic        e;
    } exp_t;

    logic          clock = 1'b0;
    logic          reset;
    logic          req_valid;
    logic          req_ready;
    logic [AW-1:0] req_addr;
    logic [2:0]    req_func3;
    logic          resp_valid;
    logic          resp_ready;
    logic [31:0]   resp_data;
    logic          resp_err;
    logic [AW-1:0] araddr;
    logic          arvalid;
    logic          arready;
    logic [31:0]   rdata;
    logic [1:0]    rresp;
    logic          rvalid;
    logic          rready;

    int n_tests = 0;
    int n_fail  = 0;

    exp_t        exp_q[$];
    exp_t        ce;
    logic [31:0] last_a;
    logic [31:0] last_d;
    logic        last_e;

    always #5 clock = ~clock;

    lsu_load_unit #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
        .clock      (clock),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .req_func3  (req_func3),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_err   (resp_err),
        .araddr     (araddr),
        .arvalid    (arvalid),
        .arready    (arready),
        .rdata      (rdata),
        .rresp      (rresp),
        .rvalid     (rvalid),
        .rready     (rready)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, required 0x%08h at %0t", name, act, req, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic req);
        chk(name, {31'b0, act}, {31'b0, req});
    endtask

    // Expected load result straight from the ISA rules: shift the word, mask to size, extend.
    function automatic void model(input logic [31:0] a, input logic [2:0] f3, input logic [31:0] rd,
                                  input logic [1:0] rr, output logic legal, output logic [31:0] d,
                                  output logic e);
        int          off;
        int          sz;
        logic [31:0] v;
        off = int'(a % 32'd4);
        sz  = (f3 == 3'd0 || f3 == 3'd4) ? 1 : (f3 == 3'd1 || f3 == 3'd5) ? 2 : (f3 == 3'd2) ? 4 : 0;
        legal = (sz != 0) && ((off % sz) == 0);
        d = 32'h0;
        e = 1'b1;
        if (legal && rr == 2'b00) begin
            v = rd >> (8 * off);
            if (sz == 1) begin
                v = v & 32'hFF;
                if (f3 == 3'd0 && v >= 32'd128) v = v | 32'hFFFF_FF00;
            end else if (sz == 2) begin
                v = v & 32'hFFFF;
                if (f3 == 3'd1 && v >= 32'h8000) v = v | 32'hFFFF_0000;
            end
            d = v;
            e = 1'b0;
        end
    endfunction

    function automatic exp_t mk(input logic [1:0] ph, input logic [31:0] ad, input logic [31:0] d, input logic e);
        exp_t x;
        x.ph = ph;
        x.ad = ad;
        x.d  = d;
        x.e  = e;
        return x;
    endfunction

    // One cycle of stimulus plus the phase the DUT must be in on the following cycle.
    task automatic cyc(input logic rst, input logic rqv, input logic [31:0] a, input logic [2:0] f,
                       input logic arr, input logic rv, input logic [31:0] rd, input logic [1:0] rr,
                       input logic rsr, input exp_t nx);
        @(negedge clock);
        reset      = rst;
        req_valid  = rqv;
        req_addr   = a;
        req_func3  = f;
        arready    = arr;
        rvalid     = rv;
        rdata      = rd;
        rresp      = rr;
        resp_ready = rsr;
        exp_q.push_back(nx);
    endtask

    // Compare process: every cycle with a prediction, check handshake outputs and held values.
    always @(posedge clock) begin
        #1;
        if (exp_q.size() > 0) begin
            ce = exp_q.pop_front();
            chk1("req_ready", req_ready, ce.ph == P_IDLE);
            chk1("arvalid", arvalid, ce.ph == P_AR);
            chk1("rready", rready, ce.ph == P_R);
            chk1("resp_valid", resp_valid, ce.ph == P_RESP);
            if (ce.ph == P_AR) begin
                chk("araddr", araddr, ce.ad);
                last_a = araddr;
            end
            if (ce.ph == P_RESP) begin
                chk("resp_data", resp_data, ce.d);
                chk1("resp_err", resp_err, ce.e);
                last_d = resp_data;
                last_e = resp_err;
            end
        end
    end

    // Full transaction: d_ar/d_r are wait cycles before arready/rvalid, d_resp before resp_ready,
    // rst_k > 0 asserts reset on that R cycle.
    task automatic run_txn(input logic [31:0] a, input logic [2:0] f3, input logic [31:0] rd,
                           input logic [1:0] rr, input int d_ar, input int d_r, input int d_resp,
                           input int rst_k);
        logic        legal;
        logic [31:0] md;
        logic        me;
        logic [31:0] ad;
        logic [1:0]  ph;
        logic [1:0]  nxt;
        logic [31:0] cd;
        logic        cdone_e;
        logic        rst;
        logic        arr;
        logic        rvl;
        logic        rsr;
        logic        did_rst;
        int          k;
        model(a, f3, rd, rr, legal, md, me);
        ad      = a & 32'hFFFF_FFFC;
        ph      = legal ? P_AR : P_RESP;
        cd      = 32'h0;
        cdone_e = 1'b1;
        did_rst = 1'b0;
        cyc(1'b0, 1'b1, a, f3, 1'b0, 1'b0, $urandom, 2'b00, 1'b0, mk(ph, ad, cd, cdone_e));
        k = 1;
        while (ph != P_IDLE) begin
            nxt = ph;
            rst = 1'b0;
            arr = 1'b0;
            rvl = 1'b0;
            rsr = 1'b0;
            case (ph)
                P_AR: begin
                    arr = (k == d_ar + 1);
                    if (arr) nxt = P_R;
                    else if (k == TO) begin
                        nxt = P_RESP; cd = 32'h0; cdone_e = 1'b1;
                    end
                end
                P_R: begin
                    rvl = (k == d_r + 1);
                    if (k == rst_k) begin
                        rst = 1'b1; nxt = P_IDLE; did_rst = 1'b1;
                    end else if (rvl) begin
                        nxt = P_RESP; cd = md; cdone_e = me;
                    end else if (k == TO) begin
                        nxt = P_RESP; cd = 32'h0; cdone_e = 1'b1;
                    end
                end
                default: begin
                    rsr = (k == d_resp + 1);
                    rvl = 1'($urandom % 2);
                    if (rsr) nxt = P_IDLE;
                end
            endcase
            cyc(rst, 1'($urandom % 2), $urandom, 3'($urandom), arr, rvl,
                (ph == P_R && rvl) ? rd : $urandom, (ph == P_R && rvl) ? rr : 2'($urandom),
                rsr, mk(nxt, ad, cd, cdone_e));
            k  = (nxt != ph) ? 1 : k + 1;
            ph = nxt;
        end
        if (did_rst)
            cyc(1'b0, 1'b0, 32'h0, 3'd0, 1'b0, 1'b1, $urandom, 2'b00, 1'b1, mk(P_IDLE, ad, 32'h0, 1'b0));
    endtask

    initial begin
        logic        lg;
        logic [31:0] md;
        logic        me;
        int          r;
        int          d_ar;
        reset      = 1'b1;
        req_valid  = 1'b0;
        req_addr   = 32'h0;
        req_func3  = 3'd0;
        arready    = 1'b0;
        rvalid     = 1'b0;
        rdata      = 32'h0;
        rresp      = 2'b00;
        resp_ready = 1'b0;
        last_a     = 32'h0;
        last_d     = 32'h0;
        last_e     = 1'b0;
        repeat (3) @(posedge clock);
        #2;
        chk1("rst_req_ready", req_ready, 1'b1);
        chk1("rst_arvalid", arvalid, 1'b0);
        chk1("rst_rready", rready, 1'b0);
        chk1("rst_resp_valid", resp_valid, 1'b0);
        chk("rst_resp_data", resp_data, 32'h0);
        chk1("rst_resp_err", resp_err, 1'b0);
        chk("rst_araddr", araddr, 32'h0);

        // Model pinned to hand-computed values.
        model(32'h8000_0003, 3'd0, 32'h80FF_1234, 2'b00, lg, md, me);
        chk("model_lb", md, 32'hFFFF_FF80);
        model(32'h8000_0002, 3'd1, 32'h9A56_78BC, 2'b00, lg, md, me);
        chk("model_lh", md, 32'hFFFF_9A56);

        cyc(1'b0, 1'b0, 32'h0, 3'd0, 1'b0, 1'b0, 32'h0, 2'b00, 1'b0, mk(P_IDLE, 32'h0, 32'h0, 1'b0));

        run_txn(32'h8000_0003, 3'd0, 32'h80FF_1234, 2'b00, 0, 0, 0, 0);
        chk("lb_araddr", last_a, 32'h8000_0000);
        chk("lb_data", last_d, 32'hFFFF_FF80);
        chk1("lb_err", last_e, 1'b0);
        run_txn(32'h8000_0001, 3'd4, 32'h9A56_78BC, 2'b00, 0, 0, 0, 0);
        chk("lbu_data", last_d, 32'h0000_0078);
        run_txn(32'h8000_0002, 3'd5, 32'h9A56_78BC, 2'b00, 0, 0, 0, 0);
        chk("lhu_data", last_d, 32'h0000_9A56);
        run_txn(32'h8000_0002, 3'd1, 32'h9A56_78BC, 2'b00, 0, 0, 0, 0);
        chk("lh_data", last_d, 32'hFFFF_9A56);
        run_txn(32'h8000_0100, 3'd2, 32'hDEAD_BEEF, 2'b00, 3, 2, 4, 0);
        chk("lw_slow_data", last_d, 32'hDEAD_BEEF);
        run_txn(32'h8000_0001, 3'd1, 32'h1111_1111, 2'b00, 0, 0, 0, 0);
        chk("lh_mis_data", last_d, 32'h0);
        chk1("lh_mis_err", last_e, 1'b1);
        run_txn(32'h8000_0002, 3'd2, 32'h1111_1111, 2'b00, 0, 0, 0, 0);
        chk1("lw_mis_err", last_e, 1'b1);
        run_txn(32'h8000_0000, 3'd3, 32'h1111_1111, 2'b00, 0, 0, 1, 0);
        chk1("f3_011_err", last_e, 1'b1);
        run_txn(32'h8000_0000, 3'd2, 32'h5555_AAAA, 2'b10, 0, 0, 0, 0);
        chk("rresp_data", last_d, 32'h0);
        chk1("rresp_err", last_e, 1'b1);
        run_txn(32'h8000_0040, 3'd2, 32'h5555_AAAA, 2'b00, 40, 0, 0, 0);
        chk1("ar_timeout_err", last_e, 1'b1);
        run_txn(32'h8000_0040, 3'd2, 32'h5555_AAAA, 2'b00, 0, 40, 2, 0);
        chk1("r_timeout_err", last_e, 1'b1);
        run_txn(32'h8000_0044, 3'd2, 32'h1234_5678, 2'b00, 0, 7, 0, 0);
        chk("r_expiry_tie_data", last_d, 32'h1234_5678);
        run_txn(32'h8000_0000, 3'd2, 32'h7777_7777, 2'b00, 0, 5, 0, 2);
        run_txn(32'h8000_0003, 3'd0, 32'h80FF_1234, 2'b00, 0, 0, 0, 0);
        chk("post_reset_lb", last_d, 32'hFFFF_FF80);

        for (int i = 0; i < 300; i++) begin
            r    = int'($urandom % 10);
            d_ar = (r < 8) ? (r % 7) : (r == 8 ? 8 : 12);
            run_txn($urandom, 3'($urandom), $urandom,
                    ($urandom % 6 == 0) ? 2'($urandom_range(1, 3)) : 2'b00,
                    d_ar, int'($urandom % 10), int'($urandom % 4),
                    ($urandom % 15 == 0) ? int'($urandom_range(1, 3)) : 0);
            repeat (int'($urandom % 3))
                cyc(1'b0, 1'b0, $urandom, 3'($urandom), 1'b0, 1'b0, $urandom, 2'b00, 1'($urandom % 2),
                    mk(P_IDLE, 32'h0, 32'h0, 1'b0));
        end

        repeat (3) @(posedge clock);
        #2;
        chk("queue_drained", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
